seven_segment_capture: RTL and testbench

SEVEN_SEGMENT_CAPTURE -- requirements
Module: seven_segment_capture

---
 rtl/seven_segment_capture.sv | 201 ++++++++++++++++++++
 tb/tb_seven_segment_capture.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_capture
// Description : Snoops a multiplexed, active-low 4-digit seven-segment bus and
//               rebuilds the displayed frame. Each digit is latched once its
//               anode/segment sample has been stable for STABLE_CYCLES
//               consecutive samples. A full set of four digits is presented
//               on digit1..digit4 with a valid/ready handshake.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               anode_active[3:0]   - active-low digit select (0111 = digit1)
//               segments[6:0]       - active-low segments, a..g = bit6..bit0
//               frame_ready         - consumer acknowledge
//               digit1..digit4[3:0] - decoded frame (4'hF blank, 4'hE bad)
//               frame_valid         - frame held on digit1..digit4
//               seg_error, anode_error, overflow - sticky error flags
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_capture #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] anode_active,
    input  logic [6:0] segments,
    input  logic       frame_ready,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       frame_valid,
    output logic       seg_error,
    output logic       anode_error,
    output logic       overflow
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] c_STABLE = 8'(STABLE_CYCLES);

    // Registered bus sample and the sample before it
    logic [3:0] r_anode;
    logic [6:0] r_seg;
    logic [3:0] r_prev_anode;
    logic [6:0] r_prev_seg;

    state_t     r_state;
    state_t     w_state_next;
    logic [7:0] r_count;
    logic [7:0] w_count_next;

    logic [3:0] r_slot [0:3];
    logic [3:0] r_mask;

    logic [3:0] w_decode;
    logic [1:0] w_idx;
    logic       w_single;
    logic       w_blank;
    logic       w_fresh;
    logic       w_latch;
    logic       w_anode_err;
    logic       w_mask_full;

    assign w_blank     = (r_anode == 4'b1111);
    assign w_mask_full = (r_mask == 4'b1111);

    always_comb begin
        w_idx    = 2'd0;
        w_single = 1'b1;
        case (r_anode)
            4'b0111: w_idx = 2'd0;
            4'b1011: w_idx = 2'd1;
            4'b1101: w_idx = 2'd2;
            4'b1110: w_idx = 2'd3;
            default: w_single = 1'b0;
        endcase
    end

    always_comb begin
        case (r_seg)
            7'b0000001: w_decode = 4'd0;
            7'b1001111: w_decode = 4'd1;
            7'b0010010: w_decode = 4'd2;
            7'b0000110: w_decode = 4'd3;
            7'b1001100: w_decode = 4'd4;
            7'b0100100: w_decode = 4'd5;
            7'b0100000: w_decode = 4'd6;
            7'b0001111: w_decode = 4'd7;
            7'b0000000: w_decode = 4'd8;
            7'b0000100: w_decode = 4'd9;
            7'b1111111: w_decode = 4'hF;
            default:    w_decode = 4'hE;
        endcase
    end

    // Next-state logic. A "fresh" sample is one the FSM treats as a new
    // start exactly as from IDLE: always in IDLE, on any anode/segment
    // change in SETTLE, and only on an anode change in HOLD.
    always_comb begin
        w_state_next = r_state;
        w_count_next = r_count;
        w_latch      = 1'b0;
        w_anode_err  = 1'b0;
        case (r_state)
            SETTLE:  w_fresh = (r_anode != r_prev_anode) || (r_seg != r_prev_seg);
            HOLD:    w_fresh = (r_anode != r_prev_anode);
            default: w_fresh = 1'b1;
        endcase

        if (!w_fresh) begin
            if (r_state == SETTLE) begin
                w_count_next = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
                if (w_count_next == c_STABLE) begin
                    w_latch      = 1'b1;
                    w_state_next = HOLD;
                end
            end
        end else if (w_blank) begin
            w_state_next = IDLE;
            w_count_next = 8'd0;
        end else if (w_single) begin
            w_count_next = 8'd1;
            // With STABLE_CYCLES of 1 the first sample already qualifies
            if (w_count_next == c_STABLE) begin
                w_latch      = 1'b1;
                w_state_next = HOLD;
            end else begin
                w_state_next = SETTLE;
            end
        end else begin
            w_anode_err  = 1'b1;
            w_state_next = IDLE;
            w_count_next = 8'd0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_count <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_anode      <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_prev_anode <= 4'b1111;
            r_prev_seg   <= 7'b1111111;
            r_mask       <= 4'b0000;
            for (int i = 0; i < 4; i++) r_slot[i] <= 4'hF;
            digit1       <= 4'hF;
            digit2       <= 4'hF;
            digit3       <= 4'hF;
            digit4       <= 4'hF;
            frame_valid  <= 1'b0;
            seg_error    <= 1'b0;
            anode_error  <= 1'b0;
            overflow     <= 1'b0;
        end else begin
            r_anode      <= anode_active;
            r_seg        <= segments;
            r_prev_anode <= r_anode;
            r_prev_seg   <= r_seg;

            // seg_error is raised when an undecodable pattern is captured
            if (w_latch) begin
                r_slot[w_idx] <= w_decode;
                if (w_decode == 4'hE) seg_error <= 1'b1;
            end
            if (w_anode_err) anode_error <= 1'b1;

            // Mask is cleared when a full frame is consumed; a latch on the
            // same edge still records its bit for the next frame.
            r_mask <= (w_mask_full ? 4'b0000 : r_mask)
                    | (w_latch ? (4'b0001 << w_idx) : 4'b0000);

            if (w_mask_full) begin
                if (!frame_valid || frame_ready) begin
                    digit1      <= r_slot[0];
                    digit2      <= r_slot[1];
                    digit3      <= r_slot[2];
                    digit4      <= r_slot[3];
                    frame_valid <= 1'b1;
                end else begin
                    overflow    <= 1'b1;
                end
            end else if (frame_valid && frame_ready) begin
                frame_valid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_capture
// Description : Self-checking bench for seven_segment_capture. Directed
//               scenarios plus randomized scanning, compared each cycle with a
//               behavioural model based on run lengths of identical samples.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_capture;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] anode_active;
    logic [6:0] segments;
    logic       frame_ready;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       frame_valid, seg_error, anode_error, overflow;

    seven_segment_capture #(.STABLE_CYCLES(STABLE)) dut (
        .clk          (clk),
        .rst          (rst),
        .anode_active (anode_active),
        .segments     (segments),
        .frame_ready  (frame_ready),
        .digit1       (digit1),
        .digit2       (digit2),
        .digit3       (digit3),
        .digit4       (digit4),
        .frame_valid  (frame_valid),
        .seg_error    (seg_error),
        .anode_error  (anode_error),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    logic [6:0] c_seg [0:9] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                7'b0000000, 7'b0000100};
    logic [3:0] c_an  [1:4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

    int passed = 0;
    int total  = 0;
    int fv_seen = 0;

    // Reference model state
    logic [3:0] m_d [1:4];
    logic [3:0] m_slot [1:4];
    logic [4:1] m_have;
    logic       m_fv, m_seg_err, m_an_err, m_ovf;
    logic [3:0] m_prev_a, m_pend_a;
    logic [6:0] m_prev_s, m_pend_s;
    int         m_run;
    logic       m_held;

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        if (s == 7'b1111111) return 4'hF;
        for (int i = 0; i < 10; i++)
            if (s == c_seg[i]) return 4'(i);
        return 4'hE;
    endfunction

    task automatic model_reset();
        for (int k = 1; k <= 4; k++) begin
            m_d[k]    = 4'hF;
            m_slot[k] = 4'hF;
        end
        m_have = 4'b0000;
        m_fv = 0; m_seg_err = 0; m_an_err = 0; m_ovf = 0;
        m_prev_a = 4'hF; m_prev_s = 7'h7F;
        m_pend_a = 4'hF; m_pend_s = 7'h7F;
        m_run = 0; m_held = 0;
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock: drive inputs, advance, update model, compare all outputs.
    task automatic step(input logic [3:0] a, input logic [6:0] s,
                        input logic rdy, input logic rs);
        logic       full;
        logic [4:1] nh;
        int         zeros;
        int         dig;
        anode_active = a; segments = s; frame_ready = rdy; rst = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            model_reset();
        end else begin
            // Handshake: a complete set of digits becomes a frame one cycle later
            full = &m_have;
            if (full) begin
                if (!m_fv || rdy) begin
                    for (int k = 1; k <= 4; k++) m_d[k] = m_slot[k];
                    m_fv = 1;
                end else begin
                    m_ovf = 1;
                end
            end else if (m_fv && rdy) begin
                m_fv = 0;
            end
            nh = full ? 4'b0000 : m_have;

            // Capture: a digit qualifies when its exact sample has repeated
            // STABLE times and it has not already been taken in this dwell.
            zeros = $countones(~m_pend_a);
            if (m_pend_a != m_prev_a) m_held = 0;
            if (m_pend_a == m_prev_a && m_pend_s == m_prev_s) m_run++;
            else m_run = 1;
            m_prev_a = m_pend_a; m_prev_s = m_pend_s;
            if (zeros >= 2) begin
                m_an_err = 1;
            end else if (zeros == 1 && !m_held && m_run == STABLE) begin
                dig = 0;
                for (int k = 1; k <= 4; k++)
                    if (m_pend_a == c_an[k]) dig = k;
                m_slot[dig] = ref_decode(m_pend_s);
                if (m_slot[dig] == 4'hE) m_seg_err = 1;
                nh[dig] = 1'b1;
                m_held = 1;
            end
            m_have = nh;
            m_pend_a = a; m_pend_s = s;
        end
        if (frame_valid) fv_seen++;
        chk("digit1", digit1, m_d[1]);
        chk("digit2", digit2, m_d[2]);
        chk("digit3", digit3, m_d[3]);
        chk("digit4", digit4, m_d[4]);
        chk("frame_valid", {3'b0, frame_valid}, {3'b0, m_fv});
        chk("seg_error",   {3'b0, seg_error},   {3'b0, m_seg_err});
        chk("anode_error", {3'b0, anode_error}, {3'b0, m_an_err});
        chk("overflow",    {3'b0, overflow},    {3'b0, m_ovf});
    endtask

    task automatic hold(input logic [3:0] a, input logic [6:0] s,
                        input logic rdy, input int n);
        for (int i = 0; i < n; i++) step(a, s, rdy, 1'b0);
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs7;
        int         len;
        logic [6:0] toggle_a, toggle_b;

        model_reset();
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        chk("reset_digit1", digit1, 4'hF);
        chk("reset_fv", {3'b0, frame_valid}, 4'h0);

        // Basic scan 1,2,3,4 with consumer always ready
        fv_seen = 0;
        for (int k = 1; k <= 4; k++) hold(c_an[k], c_seg[k], 1'b1, 6);
        hold(4'hF, 7'h7F, 1'b1, 4);
        chk("scan_fv_cycles", 4'(fv_seen), 4'd1);
        chk("scan_d1", digit1, 4'd1);
        chk("scan_d4", digit4, 4'd4);

        // Toggling digit1 must not latch; then a stable 5 latches
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        toggle_a = c_seg[0]; toggle_b = c_seg[8];
        for (int i = 0; i < 5; i++) hold(c_an[1], (i % 2) ? toggle_b : toggle_a, 1'b1, 2);
        hold(c_an[1], c_seg[5], 1'b1, 5);
        for (int k = 2; k <= 4; k++) hold(c_an[k], c_seg[k], 1'b1, 6);
        hold(4'hF, 7'h7F, 1'b1, 3);
        chk("stable_d1", digit1, 4'd5);

        // Two frames with no acknowledge: first is held, second overflows
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        for (int k = 1; k <= 4; k++) hold(c_an[k], c_seg[k], 1'b0, 6);
        for (int k = 1; k <= 4; k++) hold(c_an[k], c_seg[k + 4], 1'b0, 6);
        hold(4'hF, 7'h7F, 1'b0, 3);
        chk("ovf_flag", {3'b0, overflow}, 4'h1);
        chk("ovf_held_d1", digit1, 4'd1);
        chk("ovf_fv_before", {3'b0, frame_valid}, 4'h1);
        step(4'hF, 7'h7F, 1'b1, 1'b0);
        chk("ovf_fv_after", {3'b0, frame_valid}, 4'h0);

        // Multi-low anode, then a bad segment pattern on digit2
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        hold(4'b0011, c_seg[3], 1'b1, 6);
        chk("anode_err", {3'b0, anode_error}, 4'h1);
        hold(c_an[1], c_seg[7], 1'b1, 6);
        hold(c_an[2], 7'b1111110, 1'b1, 6);
        hold(c_an[3], c_seg[3], 1'b1, 6);
        hold(c_an[4], c_seg[9], 1'b1, 6);
        hold(4'hF, 7'h7F, 1'b1, 3);
        chk("bad_d2", digit2, 4'hE);
        chk("seg_err", {3'b0, seg_error}, 4'h1);

        // Reset mid-frame discards partial captures
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        for (int k = 1; k <= 3; k++) hold(c_an[k], c_seg[k], 1'b1, 6);
        step(4'hF, 7'h7F, 1'b1, 1'b1);
        fv_seen = 0;
        hold(c_an[4], c_seg[4], 1'b1, 6);
        hold(4'hF, 7'h7F, 1'b1, 4);
        chk("rst_no_fv", 4'(fv_seen), 4'd0);
        chk("rst_d4", digit4, 4'hF);

        // Randomized scanning against the model
        step(4'hF, 7'h7F, 1'b0, 1'b1);
        for (int r = 0; r < 220; r++) begin
            case ($urandom_range(0, 9))
                0, 1:    ra = 4'hF;
                8:       ra = 4'(~((4'b0001 << $urandom_range(0, 3)) | (4'b0001 << $urandom_range(0, 3))));
                9:       ra = 4'($urandom);
                default: ra = c_an[$urandom_range(1, 4)];
            endcase
            case ($urandom_range(0, 11))
                10:      rs7 = 7'h7F;
                11:      rs7 = 7'($urandom);
                default: rs7 = c_seg[$urandom_range(0, 9)];
            endcase
            len = $urandom_range(1, 7);
            for (int i = 0; i < len; i++)
                step(ra, rs7, ($urandom_range(0, 3) != 0), ($urandom_range(0, 300) == 0));
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
